ascon_block_packer: RTL and testbench

Upstream feeder for the ASCON encryption datapath: it takes a byte stream (plaintext or associated data) under a valid/ready handshake, packs it big-endian into 64-bit rate blocks, applies ASCON 10* padding to the final block, and presents blocks to the ASCON control FSM under a second valid/ready handshake. It removes byte-level framing and padding arithmetic from the core sequencer; the sequencer only sees whole 64-bit blocks plus a last flag.

---
 rtl/ascon_block_packer.sv | 142 ++++++++++++++
 tb/tb_ascon_block_packer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ascon_block_packer.sv
// Packs a big-endian byte stream into 64-bit ASCON rate blocks with 10* padding.
// Optional ASCON_PACKER_STATS_EN adds block_count_o, a saturating handshake counter.
module ascon_block_packer (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    input  logic        byte_last_i,
    output logic        byte_ready_o,
    input  logic        flush_i,
    output logic [63:0] block_o,
    output logic        block_valid_o,
    output logic        block_last_o,
`ifdef ASCON_PACKER_STATS_EN
    output logic [15:0] block_count_o,
`endif
    input  logic        block_ready_i
);

    // state | meaning
    // FILL  | accepting bytes into the block register
    // HOLD  | full or padded block presented, waiting for consumer
    // PAD   | standalone 0x80.. block after a message that ended on a block boundary
    typedef enum logic [1:0] {FILL, HOLD, PAD} state_t;

    localparam logic [63:0] PAD_BLOCK = 64'h8000_0000_0000_0000;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [63:0] block_q, block_d;
    logic        last_q, last_d;
    logic        pad_q, pad_d;
    logic [2:0]  idx_inc;
    logic [63:0] lane_byte, lane_pad_cur, lane_pad_next;
    logic        msg_end;

    // The block register is zero on every entry to FILL, so lanes can be OR-ed in.
    assign idx_inc       = idx_q + 3'd1;
    assign lane_byte     = {byte_i, 56'd0} >> {idx_q, 3'b000};
    assign lane_pad_cur  = PAD_BLOCK >> {idx_q, 3'b000};
    assign lane_pad_next = PAD_BLOCK >> {idx_inc, 3'b000};
    assign msg_end       = byte_last_i | flush_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        block_d = block_q;
        last_d  = last_q;
        pad_d   = pad_q;
        case (state_q)
            FILL: begin
                if (byte_valid_i) begin
                    block_d = block_q | lane_byte;
                    if (idx_q == 3'd7) begin
                        state_d = HOLD;
                        idx_d   = 3'd0;
                        last_d  = 1'b0;
                        pad_d   = msg_end;
                    end else if (msg_end) begin
                        block_d = block_q | lane_byte | lane_pad_next;
                        state_d = HOLD;
                        idx_d   = 3'd0;
                        last_d  = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                    end
                end else if (flush_i) begin
                    block_d = block_q | lane_pad_cur;
                    state_d = HOLD;
                    idx_d   = 3'd0;
                    last_d  = 1'b1;
                end
            end
            HOLD: begin
                if (block_ready_i) begin
                    if (pad_q) begin
                        state_d = PAD;
                        block_d = PAD_BLOCK;
                        last_d  = 1'b1;
                    end else begin
                        state_d = FILL;
                        idx_d   = 3'd0;
                        block_d = 64'd0;
                        last_d  = 1'b0;
                    end
                end
            end
            PAD: begin
                if (block_ready_i) begin
                    state_d = FILL;
                    idx_d   = 3'd0;
                    block_d = 64'd0;
                    last_d  = 1'b0;
                    pad_d   = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = 3'd0;
                block_d = 64'd0;
                last_d  = 1'b0;
                pad_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= FILL;
            idx_q   <= 3'd0;
            block_q <= 64'd0;
            last_q  <= 1'b0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            block_q <= block_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
        end
    end

    assign byte_ready_o  = (state_q == FILL);
    assign block_valid_o = (state_q != FILL);
    assign block_o       = block_q;
    assign block_last_o  = last_q;

`ifdef ASCON_PACKER_STATS_EN
    logic [15:0] count_q;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            count_q <= 16'd0;
        end else if (block_valid_o && block_ready_i && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign block_count_o = count_q;
`endif

endmodule

// File: tb/tb_ascon_block_packer.sv
// Directed bench for ascon_block_packer: inputs driven and outputs sampled on the falling edge.
module tb_ascon_block_packer;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_last_i;
    logic        byte_ready_o;
    logic        flush_i;
    logic [63:0] block_o;
    logic        block_valid_o;
    logic        block_last_o;
    logic        block_ready_i;
`ifdef ASCON_PACKER_STATS_EN
    logic [15:0] block_count_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock_i = ~clock_i;

    ascon_block_packer dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_last_i   (byte_last_i),
        .byte_ready_o  (byte_ready_o),
        .flush_i       (flush_i),
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .block_last_o  (block_last_o),
`ifdef ASCON_PACKER_STATS_EN
        .block_count_o (block_count_o),
`endif
        .block_ready_i (block_ready_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the byte is taken on the next rising edge.
    task automatic push(input logic [7:0] b, input logic last, input logic fl);
        byte_i       = b;
        byte_valid_i = 1'b1;
        byte_last_i  = last;
        flush_i      = fl;
        @(negedge clock_i);
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic expect_block(input string tag, input logic [63:0] blk, input logic last);
        check({tag, "_valid"}, 64'(block_valid_o), 64'd1);
        check({tag, "_ready"}, 64'(byte_ready_o), 64'd0);
        check({tag, "_block"}, block_o, blk);
        check({tag, "_last"}, 64'(block_last_o), 64'(last));
    endtask

    initial begin
        reset_i       = 1'b0;
        byte_i        = 8'h00;
        byte_valid_i  = 1'b0;
        byte_last_i   = 1'b0;
        flush_i       = 1'b0;
        block_ready_i = 1'b1;
        repeat (3) @(negedge clock_i);
        check("rst_ready", 64'(byte_ready_o), 64'd1);
        check("rst_valid", 64'(block_valid_o), 64'd0);
        check("rst_last", 64'(block_last_o), 64'd0);
        check("rst_block", block_o, 64'd0);
`ifdef ASCON_PACKER_STATS_EN
        check("rst_count", 64'(block_count_o), 64'd0);
`endif
        reset_i = 1'b1;
        @(negedge clock_i);

        // Eight bytes ending the message: full block then a separate pad block.
        for (int i = 1; i <= 8; i++) push(8'(i), (i == 8), 1'b0);
        expect_block("full8", 64'h0102030405060708, 1'b0);
        @(negedge clock_i);
        expect_block("pad8", 64'h8000000000000000, 1'b1);
        @(negedge clock_i);
        check("pad8_done_valid", 64'(block_valid_o), 64'd0);
        check("pad8_done_ready", 64'(byte_ready_o), 64'd1);

        // Short message padded in place.
        push(8'hAA, 1'b0, 1'b0);
        push(8'hBB, 1'b0, 1'b0);
        check("short_notyet", 64'(block_valid_o), 64'd0);
        push(8'hCC, 1'b1, 1'b0);
        expect_block("short3", 64'hAABBCC8000000000, 1'b1);
        @(negedge clock_i);
        check("short3_done", 64'(block_valid_o), 64'd0);

        // Flush on an empty block.
        flush_i = 1'b1;
        @(negedge clock_i);
        flush_i = 1'b0;
        expect_block("flush0", 64'h8000000000000000, 1'b1);
        @(negedge clock_i);

        // Flush after three bytes places the pad at lane 3.
        push(8'h01, 1'b0, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        push(8'h03, 1'b0, 1'b0);
        flush_i = 1'b1;
        @(negedge clock_i);
        flush_i = 1'b0;
        expect_block("flush3", 64'h0102038000000000, 1'b1);
        @(negedge clock_i);

        // Flush together with a byte acts as the last byte.
        push(8'h55, 1'b0, 1'b1);
        expect_block("flushbyte", 64'h5580000000000000, 1'b1);
        @(negedge clock_i);

        // Backpressure: block held stable for five cycles.
        block_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i), 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            expect_block("stall", 64'h1011121314151617, 1'b0);
            @(negedge clock_i);
        end
        block_ready_i = 1'b1;
        @(negedge clock_i);
        check("stall_release", 64'(byte_ready_o), 64'd1);
        push(8'h18, 1'b0, 1'b0);
        push(8'h19, 1'b0, 1'b0);
        push(8'h1A, 1'b1, 1'b0);
        expect_block("tail11", 64'h18191A8000000000, 1'b1);
        @(negedge clock_i);

        // Asynchronous reset mid-message discards partial bytes.
        for (int i = 0; i < 4; i++) push(8'(8'hF0 + i), 1'b0, 1'b0);
        reset_i = 1'b0;
        #1;
        check("midrst_ready", 64'(byte_ready_o), 64'd1);
        check("midrst_valid", 64'(block_valid_o), 64'd0);
        check("midrst_block", block_o, 64'd0);
        check("midrst_last", 64'(block_last_o), 64'd0);
        @(negedge clock_i);
        reset_i = 1'b1;
        @(negedge clock_i);
        for (int i = 0; i < 8; i++) push(8'(8'h21 + i), 1'b0, 1'b0);
        expect_block("clean8", 64'h2122232425262728, 1'b0);
        @(negedge clock_i);
        check("clean8_done", 64'(block_valid_o), 64'd0);

`ifdef ASCON_PACKER_STATS_EN
        // 17-byte message: two full blocks plus one padded block.
        reset_i = 1'b0;
        @(negedge clock_i);
        reset_i = 1'b1;
        @(negedge clock_i);
        for (int i = 0; i < 17; i++) begin
            push(8'(i), (i == 16), 1'b0);
            if (block_valid_o) @(negedge clock_i);
        end
        check("stats_count", 64'(block_count_o), 64'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
